// File: rtl/gcd_arbiter_if.sv
// Requester, gcd-side and status signals shared between gcd_arbiter and its surroundings.
interface gcd_arbiter_if #(
    parameter int unsigned W = 128,
    parameter int unsigned N = 4
);
    localparam int unsigned IW = $clog2(N);

    logic [N-1:0]   req_val;
    logic [N-1:0]   req_rdy;
    logic [N*W-1:0] req_bits_A;
    logic [N*W-1:0] req_bits_B;
    logic [N-1:0]   resp_val;
    logic [N-1:0]   resp_rdy;
    logic [W-1:0]   resp_bits_data;
    logic [W-1:0]   operands_bits_A;
    logic [W-1:0]   operands_bits_B;
    logic           operands_val;
    logic           operands_rdy;
    logic [W-1:0]   result_bits_data;
    logic           result_val;
    logic           result_rdy;
    logic [IW-1:0]  grant_idx;
    logic           busy;

    modport master (
        input  req_val, req_bits_A, req_bits_B, resp_rdy,
        input  operands_rdy, result_bits_data, result_val,
        output req_rdy, resp_val, resp_bits_data,
        output operands_bits_A, operands_bits_B, operands_val, result_rdy,
        output grant_idx, busy
    );

    modport slave (
        output req_val, req_bits_A, req_bits_B, resp_rdy,
        output operands_rdy, result_bits_data, result_val,
        input  req_rdy, resp_val, resp_bits_data,
        input  operands_bits_A, operands_bits_B, operands_val, result_rdy,
        input  grant_idx, busy
    );
endinterface

// File: rtl/gcd_arbiter.sv
// Round-robin arbiter sharing one gcd unit among N requesters, one transaction at a time.
module gcd_arbiter #(
    parameter int unsigned W = 128,
    parameter int unsigned N = 4
) (
    input logic           clk,
    input logic           reset,
    gcd_arbiter_if.master bus
);
    localparam int unsigned IW = $clog2(N);
    localparam int unsigned SW = IW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] grant;
    logic [IW-1:0] winner;
    logic [IW-1:0] next_ptr;
    logic          found;
    logic [SW-1:0] cand;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic [W-1:0]  res;
    logic [W-1:0]  sel_a;
    logic [W-1:0]  sel_b;
    logic          operands_val;
    logic          result_rdy;
    logic          busy;
    logic [N-1:0]  resp_val;
    logic [N-1:0]  req_rdy;

    // Search upward from ptr; the wrap is at N so indices >= N are never visited.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = SW'(ptr) + SW'(k);
            if (cand >= SW'(N)) begin
                cand = cand - SW'(N);
            end
            if (!found && bus.req_val[cand[IW-1:0]]) begin
                found  = 1'b1;
                winner = cand[IW-1:0];
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (winner == IW'(i)) begin
                sel_a = bus.req_bits_A[i*W +: W];
                sel_b = bus.req_bits_B[i*W +: W];
            end
        end
    end

    // Accept is the only combinational output: it follows req_val in IDLE.
    always_comb begin
        req_rdy = '0;
        if (state == IDLE && found) begin
            req_rdy[winner] = 1'b1;
        end
    end

    assign next_ptr = (grant == IW'(N - 1)) ? '0 : grant + 1'b1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            ptr          <= '0;
            grant        <= '0;
            op_a         <= '0;
            op_b         <= '0;
            res          <= '0;
            operands_val <= 1'b0;
            result_rdy   <= 1'b0;
            resp_val     <= '0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant        <= winner;
                        op_a         <= sel_a;
                        op_b         <= sel_b;
                        operands_val <= 1'b1;
                        busy         <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.operands_rdy) begin
                        operands_val <= 1'b0;
                        result_rdy   <= 1'b1;
                        state        <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.result_val) begin
                        res        <= bus.result_bits_data;
                        result_rdy <= 1'b0;
                        resp_val   <= N'(1) << grant;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (bus.resp_rdy[grant]) begin
                        ptr      <= next_ptr;
                        resp_val <= '0;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_rdy         = req_rdy;
    assign bus.resp_val        = resp_val;
    assign bus.resp_bits_data  = res;
    assign bus.operands_bits_A = op_a;
    assign bus.operands_bits_B = op_b;
    assign bus.operands_val    = operands_val;
    assign bus.result_rdy      = result_rdy;
    assign bus.grant_idx       = grant;
    assign bus.busy            = busy;
endmodule

// File: tb/tb_gcd_arbiter.sv
// Bench for gcd_arbiter: behavioural gcd responder plus a transaction-level round-robin model.
module tb_gcd_arbiter;
    localparam int unsigned W     = 128;
    localparam int unsigned N     = 4;
    localparam int unsigned IW    = $clog2(N);
    localparam int unsigned DEPTH = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    gcd_arbiter_if #(.W(W), .N(N)) bus ();
    gcd_arbiter #(.W(W), .N(N)) dut (.clk(clk), .reset(reset), .bus(bus));

    int vectors = 0;
    int miscompares = 0;

    logic [W-1:0] lst_a [N][DEPTH];
    logic [W-1:0] lst_b [N][DEPTH];
    int           lst_n [N];
    int           lst_i [N];

    int           ptr_m;
    bit           outstanding;
    int           cur;
    logic [W-1:0] exp_a, exp_b, exp_res;
    int           grant_log [$];
    logic [W-1:0] resp_log [$];
    int           resp_len [$];
    int           gcd_lat_fixed = -1;

    function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x = a;
        logic [W-1:0] y = b;
        logic [W-1:0] t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Stand-in for the attached gcd: accepts when idle, answers after a few cycles.
    bit           g_busy;
    bit           g_rv;
    int           g_cnt;
    logic [W-1:0] g_res;
    always @(posedge clk) begin
        if (!reset) begin
            g_busy <= 1'b0;
            g_rv   <= 1'b0;
            g_cnt  <= 0;
            g_res  <= '0;
        end else if (!g_busy) begin
            if (bus.operands_val) begin
                g_busy <= 1'b1;
                g_res  <= ref_gcd(bus.operands_bits_A, bus.operands_bits_B);
                g_cnt  <= (gcd_lat_fixed >= 0) ? gcd_lat_fixed : int'($urandom_range(0, 4));
            end
        end else if (g_rv) begin
            if (bus.result_rdy) begin
                g_rv   <= 1'b0;
                g_busy <= 1'b0;
            end
        end else if (g_cnt == 0) begin
            g_rv <= 1'b1;
        end else begin
            g_cnt <= g_cnt - 1;
        end
    end
    assign bus.operands_rdy     = !g_busy;
    assign bus.result_val       = g_rv;
    assign bus.result_bits_data = g_res;

    function automatic bit pending_any();
        for (int i = 0; i < N; i++) if (lst_i[i] < lst_n[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic clear_lists();
        for (int i = 0; i < N; i++) begin
            lst_n[i] = 0;
            lst_i[i] = 0;
        end
        grant_log.delete();
        resp_log.delete();
        resp_len.delete();
    endtask

    task automatic push_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        lst_a[i][lst_n[i]] = a;
        lst_b[i][lst_n[i]] = b;
        lst_n[i]++;
    endtask

    // Drives queued requests and checks every cycle against the round-robin model.
    task automatic run_traffic(input int budget, input int rdy_pct, input int hold);
        int cyc = 0;
        bit resp_due = 0;
        bit in_resp = 0;
        bit opval_due = 0;
        int rlen = 0;
        int pick;
        logic [N-1:0] rv, rr, exp_rdy, exp_rv;
        while ((pending_any() || outstanding) && cyc < budget) begin
            @(negedge clk);
            if (resp_due) begin
                in_resp  = 1;
                resp_due = 0;
                rlen     = 0;
            end
            rv = '0;
            rr = '0;
            for (int i = 0; i < N; i++) begin
                rv[i] = (lst_i[i] < lst_n[i]);
                if (rv[i]) begin
                    bus.req_bits_A[i*W +: W] = lst_a[i][lst_i[i]];
                    bus.req_bits_B[i*W +: W] = lst_b[i][lst_i[i]];
                end else begin
                    bus.req_bits_A[i*W +: W] = W'($urandom);
                    bus.req_bits_B[i*W +: W] = W'($urandom);
                end
                rr[i] = ($urandom_range(0, 99) < rdy_pct);
            end
            if (in_resp && hold > 0) rr[cur] = (rlen >= hold);
            bus.req_val  = rv;
            bus.resp_rdy = rr;
            #1;
            pick = -1;
            if (!outstanding)
                for (int k = 0; k < N; k++)
                    if (pick < 0 && rv[(ptr_m + k) % N]) pick = (ptr_m + k) % N;
            exp_rdy = (pick >= 0) ? (N'(1) << pick) : '0;
            exp_rv  = in_resp ? (N'(1) << cur) : '0;

            vectors++;
            if (bus.req_rdy !== exp_rdy) begin
                miscompares++;
                $display("FAIL req_rdy: got %b expected %b at cycle %0d", bus.req_rdy, exp_rdy, cyc);
            end
            vectors++;
            if (bus.busy !== outstanding) begin
                miscompares++;
                $display("FAIL busy: got %b expected %b at cycle %0d", bus.busy, outstanding, cyc);
            end
            vectors++;
            if (bus.resp_val !== exp_rv) begin
                miscompares++;
                $display("FAIL resp_val: got %b expected %b at cycle %0d", bus.resp_val, exp_rv, cyc);
            end
            if (in_resp) begin
                vectors++;
                if (bus.resp_bits_data !== exp_res) begin
                    miscompares++;
                    $display("FAIL resp_data: got %0d expected %0d", bus.resp_bits_data, exp_res);
                end
            end
            if (opval_due) begin
                vectors++;
                if (bus.operands_val !== 1'b1 || bus.operands_bits_A !== exp_a || bus.operands_bits_B !== exp_b) begin
                    miscompares++;
                    $display("FAIL operands: got val=%b A=%0d B=%0d expected val=1 A=%0d B=%0d",
                             bus.operands_val, bus.operands_bits_A, bus.operands_bits_B, exp_a, exp_b);
                end
                opval_due = 0;
            end else if (!outstanding) begin
                vectors++;
                if (bus.operands_val !== 1'b0) begin
                    miscompares++;
                    $display("FAIL operands_val_idle: got %b expected 0", bus.operands_val);
                end
            end
            if (!outstanding || in_resp) begin
                vectors++;
                if (bus.result_rdy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL result_rdy_idle: got %b expected 0", bus.result_rdy);
                end
            end
            if (outstanding) begin
                vectors++;
                if (bus.grant_idx !== IW'(cur)) begin
                    miscompares++;
                    $display("FAIL grant_idx: got %0d expected %0d", bus.grant_idx, cur);
                end
            end

            if (pick >= 0) begin
                outstanding = 1;
                cur         = pick;
                exp_a       = lst_a[pick][lst_i[pick]];
                exp_b       = lst_b[pick][lst_i[pick]];
                exp_res     = ref_gcd(exp_a, exp_b);
                lst_i[pick]++;
                grant_log.push_back(pick);
                opval_due = 1;
            end else if (in_resp && rr[cur]) begin
                resp_log.push_back(bus.resp_bits_data);
                resp_len.push_back(rlen + 1);
                outstanding = 0;
                in_resp     = 0;
                ptr_m       = (cur + 1) % N;
            end else if (in_resp) begin
                rlen++;
            end else if (outstanding && bus.result_val && bus.result_rdy) begin
                resp_due = 1;
            end
            cyc++;
        end
        vectors++;
        if (pending_any() || outstanding) begin
            miscompares++;
            $display("FAIL traffic_timeout: still busy after %0d cycles, expected drain", budget);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        vectors++;
        if ({bus.req_rdy, bus.resp_val, bus.operands_val, bus.result_rdy, bus.busy} !== '0 || bus.grant_idx !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got req_rdy=%b resp_val=%b opv=%b rrdy=%b busy=%b gidx=%0d expected all 0",
                     bus.req_rdy, bus.resp_val, bus.operands_val, bus.result_rdy, bus.busy, bus.grant_idx);
        end
        bus.req_val = N'(1) << 2;
        #1;
        vectors++;
        if (bus.req_rdy !== (N'(1) << 2)) begin
            miscompares++;
            $display("FAIL reset_pending_rdy: got %b expected 0100", bus.req_rdy);
        end
        bus.req_val = '0;
        outstanding = 0;
        ptr_m = 0;
    endtask

    task automatic test_single();
        clear_lists();
        push_req(0, W'(12), W'(18));
        run_traffic(200, 100, 0);
        vectors++;
        if (grant_log.size() != 1 || grant_log[0] != 0 || resp_log[0] !== W'(6)) begin
            miscompares++;
            $display("FAIL single: got %0d grants first=%0d data=%0d expected 1 grant to 0 data 6",
                     grant_log.size(), grant_log[0], resp_log[0]);
        end
        clear_lists();
        push_req(0, W'(5), W'(10));
        push_req(1, W'(8), W'(12));
        run_traffic(300, 100, 0);
        vectors++;
        if (grant_log.size() != 2 || grant_log[0] != 1 || grant_log[1] != 0) begin
            miscompares++;
            $display("FAIL ptr_after_single: got order %0d,%0d expected 1,0", grant_log[0], grant_log[1]);
        end
    endtask

    task automatic test_all_at_once();
        int eg [4];
        int er [4];
        eg = '{0, 1, 2, 3};
        er = '{6, 7, 1, 25};
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        outstanding = 0;
        ptr_m = 0;
        clear_lists();
        push_req(0, W'(12), W'(18));
        push_req(1, W'(35), W'(49));
        push_req(2, W'(17), W'(5));
        push_req(3, W'(100), W'(75));
        run_traffic(500, 100, 0);
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (i >= grant_log.size() || grant_log[i] != eg[i] || resp_log[i] !== W'(er[i])) begin
                miscompares++;
                $display("FAIL all_at_once[%0d]: got %0d grants, this one %0d data %0d expected grant %0d data %0d",
                         i, grant_log.size(), grant_log[i], resp_log[i], eg[i], er[i]);
            end
        end
    endtask

    task automatic test_rr_wrap();
        clear_lists();
        push_req(0, W'(4), W'(2));
        push_req(2, W'(9), W'(3));
        run_traffic(300, 100, 0);
        vectors++;
        if (grant_log.size() != 2 || grant_log[0] != 0 || grant_log[1] != 2) begin
            miscompares++;
            $display("FAIL rr_wrap_after_3: got order %0d,%0d expected 0,2", grant_log[0], grant_log[1]);
        end
        clear_lists();
        push_req(1, W'(6), W'(4));
        run_traffic(200, 100, 0);
        clear_lists();
        push_req(0, W'(15), W'(10));
        push_req(2, W'(21), W'(14));
        run_traffic(300, 100, 0);
        vectors++;
        if (grant_log.size() != 2 || grant_log[0] != 2 || grant_log[1] != 0 || resp_log[0] !== W'(7)) begin
            miscompares++;
            $display("FAIL rr_wrap_after_1: got order %0d,%0d data %0d expected 2,0 data 7",
                     grant_log[0], grant_log[1], resp_log[0]);
        end
    endtask

    task automatic test_back_pressure();
        clear_lists();
        push_req(1, W'(9), W'(6));
        push_req(0, W'(4), W'(6));
        push_req(2, W'(14), W'(21));
        run_traffic(600, 50, 10);
        vectors++;
        if (grant_log.size() != 3 || grant_log[0] != 1 || resp_log[0] !== W'(3) || resp_len[0] != 11) begin
            miscompares++;
            $display("FAIL back_pressure: got first grant %0d data %0d held %0d cycles expected 1 data 3 held 11",
                     grant_log[0], resp_log[0], resp_len[0]);
        end
    endtask

    task automatic test_reset_mid_wait();
        int bad = 0;
        gcd_lat_fixed = 20;
        @(negedge clk);
        bus.req_val = N'(1) << 2;
        bus.req_bits_A[2*W +: W] = W'(1000);
        bus.req_bits_B[2*W +: W] = W'(3);
        bus.resp_rdy = '1;
        #1;
        vectors++;
        if (bus.req_rdy !== (N'(1) << 2)) begin
            miscompares++;
            $display("FAIL mid_accept: got %b expected 0100", bus.req_rdy);
        end
        @(negedge clk);
        bus.req_val = '0;
        #1;
        vectors++;
        if (bus.operands_val !== 1'b1 || bus.operands_bits_A !== W'(1000)) begin
            miscompares++;
            $display("FAIL mid_issue: got val=%b A=%0d expected 1 and 1000", bus.operands_val, bus.operands_bits_A);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.result_rdy !== 1'b1 || bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_wait: got result_rdy=%b busy=%b expected 1 1", bus.result_rdy, bus.busy);
        end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        vectors++;
        if ({bus.req_rdy, bus.resp_val, bus.operands_val, bus.result_rdy, bus.busy} !== '0 || bus.grant_idx !== '0) begin
            miscompares++;
            $display("FAIL mid_reset_outputs: got req_rdy=%b resp_val=%b opv=%b rrdy=%b busy=%b gidx=%0d expected all 0",
                     bus.req_rdy, bus.resp_val, bus.operands_val, bus.result_rdy, bus.busy, bus.grant_idx);
        end
        repeat (30) begin
            @(negedge clk);
            if (bus.resp_val !== '0 || bus.busy !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL mid_dropped: got %0d cycles with response or busy expected 0", bad);
        end
        bus.resp_rdy = '0;
        gcd_lat_fixed = -1;
        outstanding = 0;
        ptr_m = 0;
        clear_lists();
        push_req(0, W'(21), W'(14));
        push_req(3, W'(10), W'(4));
        run_traffic(300, 100, 0);
        vectors++;
        if (grant_log.size() != 2 || grant_log[0] != 0 || grant_log[1] != 3) begin
            miscompares++;
            $display("FAIL ptr_after_reset: got order %0d,%0d expected 0,3", grant_log[0], grant_log[1]);
        end
    endtask

    task automatic test_zero_operand();
        clear_lists();
        push_req(3, W'(0), W'(7));
        run_traffic(200, 100, 0);
        vectors++;
        if (grant_log.size() != 1 || grant_log[0] != 3 || resp_log[0] !== W'(7)) begin
            miscompares++;
            $display("FAIL zero_operand: got %0d grants data %0d expected 1 grant data 7", grant_log.size(), resp_log[0]);
        end
    endtask

    task automatic test_random();
        int total;
        int cnt [N];
        int seen;
        for (int r = 0; r < 4; r++) begin
            clear_lists();
            total = 0;
            for (int i = 0; i < N; i++) begin
                cnt[i] = int'($urandom_range(0, DEPTH - 1));
                for (int j = 0; j < cnt[i]; j++) begin
                    logic [W-1:0] g;
                    g = W'($urandom_range(1, 1000));
                    push_req(i, g * W'($urandom_range(0, 5000)), g * W'($urandom_range(0, 5000)));
                end
                total += cnt[i];
            end
            run_traffic(4000, 70, 0);
            vectors++;
            if (grant_log.size() != total || resp_log.size() != total) begin
                miscompares++;
                $display("FAIL random_count: got %0d grants %0d responses expected %0d", grant_log.size(), resp_log.size(), total);
            end
            for (int i = 0; i < N; i++) begin
                seen = 0;
                foreach (grant_log[k]) if (grant_log[k] == i) seen++;
                vectors++;
                if (seen != cnt[i]) begin
                    miscompares++;
                    $display("FAIL random_per_req[%0d]: got %0d grants expected %0d", i, seen, cnt[i]);
                end
            end
        end
    endtask

    initial begin
        reset           = 1'b0;
        bus.req_val     = '0;
        bus.req_bits_A  = '0;
        bus.req_bits_B  = '0;
        bus.resp_rdy    = '0;
        outstanding     = 0;
        ptr_m           = 0;
        cur             = 0;
        test_reset();
        test_single();
        test_all_at_once();
        test_rr_wrap();
        test_back_pressure();
        test_reset_mid_wait();
        test_zero_operand();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/gcd_arbiter.md
# gcd_arbiter

Round-robin arbiter that shares one `gcd` unit among `N` requesters. Each requester presents an operand pair over a val/rdy handshake. The arbiter grants one requester at a time and forwards its operands to the `gcd` operand port. It then collects the result and returns it to the granted requester before starting the next grant. It sits between requester blocks and a single `gcd#(W)` instance, and connects directly to that instance's operand and result ports.

## Interface
- `W`, 128, operand/result bit width; must match the attached `gcd` instance.
- `N`, 4, number of requesters; legal range 2..16. `IW = $clog2(N)`.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-low; sampled on the rising edge of `clk`.
- `req_val` in N: per-requester operands valid.
- `req_rdy` out N: per-requester operands accepted; one-hot or zero.
- `req_bits_A` in N*W: requester i's A operand is bits [i*W +: W].
- `req_bits_B` in N*W: requester i's B operand is bits [i*W +: W].
- `resp_val` out N: per-requester result valid; one-hot or zero.
- `resp_rdy` in N: per-requester result accepted.
- `resp_bits_data` out W: result; shared by all requesters, qualified by `resp_val`.
- `operands_bits_A` out W: to `gcd`.
- `operands_bits_B` out W: to `gcd`.
- `operands_val` out 1: to `gcd`.
- `operands_rdy` in 1: from `gcd`.
- `result_bits_data` in W: from `gcd`.
- `result_val` in 1: from `gcd`.
- `result_rdy` out 1: to `gcd`.
- `grant_idx` out IW: index of the current or most recent grant.
- `busy` out 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Only one transaction is outstanding at a time.
- Internal registers: `ptr` (IW bits), `grant` (IW bits), `opA` and `opB` (W bits each), `res` (W bits).
- **IDLE**
  - Winner = first i with `req_val[i]=1`, searching from `ptr` upward with wrap modulo N.
  - If a winner exists: `req_rdy[winner]=1` combinationally this cycle. On the edge, latch `grant`=winner, `opA`/`opB` = winner's operands, and go to ISSUE.
  - If no winner exists: `req_rdy=0` and the FSM stays in IDLE.
- **ISSUE**
  - `operands_val=1`, `operands_bits_A/B` = `opA`/`opB`.
  - When `operands_rdy=1`, go to WAIT.
- **WAIT**
  - `result_rdy=1`.
  - When `result_val=1`, latch `res` = `result_bits_data` and go to RESP.
- **RESP**
  - `resp_val[grant]=1`, `resp_bits_data` = `res`.
  - When `resp_rdy[grant]=1`, set `ptr` = (`grant`+1) mod N and go to IDLE.
  - `resp_rdy` of non-granted requesters is ignored.
- Wrap rule: when N is not a power of two, (`grant`+1) wraps to 0 at N, and the search never visits an index ≥ N.
- `req_rdy` is 0 in every state other than IDLE. A requester holding `req_val` waits; it is never dropped.
- `operands_val` is 0 outside ISSUE. `result_rdy` is 0 outside WAIT.
- `resp_bits_data` shows `res` in every state; it is meaningful only while `resp_val` is high.
- `grant_idx` = `grant`.
- Fairness: a requester holding `req_val` continuously is granted within N transactions.
- `gcd` is driven from registered operands, so requesters may change their inputs after the accept cycle.

## Timing
- Reset (`reset=0` at an edge), from any state:
  - FSM goes to IDLE; `ptr`, `grant`, `opA`, `opB`, `res` = 0.
  - Following cycle: `req_rdy=0` unless a request is pending (IDLE arbitration is combinational), `resp_val=0`, `operands_val=0`, `result_rdy=0`, `busy=0`, `grant_idx=0`.
  - Reset mid-transaction drops that transaction; no response is issued.
  - The attached `gcd` must be reset in the same cycle (system-level wiring drives its active-high reset with `~reset`).
- Accept edge at cycle 0 → `operands_val` high from cycle 1.
- With `operands_rdy` already high: WAIT at cycle 2; `result_rdy` high from cycle 2.
- `result_val` in cycle k → `resp_val` high from cycle k+1.
- `resp_rdy` in cycle m → IDLE at m+1; a new accept is possible in cycle m+1.
- Minimum overhead: 3 cycles plus `gcd` compute time per transaction.
- No combinational path from `result_*` to `resp_*`, or from `req_*` to `operands_*`.
- Combinational paths exist from `req_val` to `req_rdy` only, and from `operands_rdy`/`result_val` to state only.
- Simultaneous requests resolve purely by `ptr` order. A `req_val` that rises in the same cycle the FSM returns to IDLE competes normally.

## Test plan
- **Single request:** requester 0 sends A=12, B=18 → `req_rdy[0]` pulses for 1 cycle; `operands_val` high with 12/18; `resp_val[0]=1` with `resp_bits_data`=6; `ptr` becomes 1.
- **All requesters at once (N=4):** every `req_val` high from reset, pairs (12,18), (35,49), (17,5), (100,75) → grants in order 0,1,2,3; responses 6, 7, 1, 25, each on its own `resp_val` bit.
- **Round-robin wrap:** after a grant to 3, requesters 0 and 2 request together → 0 is granted first; then after a grant to 1, requesters 0 and 2 request together → 2 is granted first.
- **Back-pressure:** hold `resp_rdy[1]=0` for 10 cycles with A=9, B=6 → `resp_val[1]` and `resp_bits_data`=3 stay stable; `req_rdy` stays 0 for other requesters; `busy`=1 throughout.
- **Reset mid-WAIT:** drive `reset=0` for 1 cycle while `gcd` is computing (A=1000, B=3) → next cycle all val/rdy outputs are 0 and `busy`=0; no `resp_val` ever appears for that request; `ptr`=0.
- **Zero operand:** A=0, B=7 → `resp_bits_data` equals the `gcd` output (7), delivered with normal handshake timing.
